// File: rtl/jogo_memoria_pkg.sv
// Purpose : shared constants, boot-time sequence table and helpers for the memory-game datapath.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: default N_BOTOES/DEPTH/TIMEOUT, SEQ_INIT (sequence loaded into the RAM at
//           elaboration), seq_word() table lookup, one_hot() validity check.
package jogo_memoria_pkg;

  localparam int N_BOTOES_DEF = 4;
  localparam int DEPTH_DEF    = 16;
  localparam int TIMEOUT_DEF  = 5000;

  // Built-in game sequence; memories deeper than the table repeat it.
  localparam int SEQ_LEN = 16;
  localparam logic [3:0] SEQ_INIT [SEQ_LEN] = '{
    4'b0100, 4'b0010, 4'b1000, 4'b0001,
    4'b0010, 4'b0100, 4'b0001, 4'b1000,
    4'b0100, 4'b0001, 4'b0010, 4'b1000,
    4'b0001, 4'b0100, 4'b1000, 4'b0010
  };

  // Table entry for RAM address idx, zero-extended to 32 bits.
  function automatic logic [31:0] seq_word(input int idx);
    logic [3:0] k;
    k = 4'(idx);
    return {28'd0, SEQ_INIT[k]};
  endfunction

  // True when exactly one bit is set.
  function automatic logic one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/ram_sync_param.sv
// Purpose : DEPTH x W sequence RAM, synchronous read, read-before-write on same address.
// Latency : read data 1 cycle after address; written data readable from the following cycle.
// Backpressure: none; one access per cycle, writes masked while reset is high.
// Ports   : clock, reset (clears only the read register), we/addr/wdata write port, rdata.
module ram_sync_param
  import jogo_memoria_pkg::*;
#(
  parameter int W      = N_BOTOES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  typedef logic [W-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = W'(seq_word(i));
    end
    return m;
  endfunction

  // Contents come from the elaborated image and survive reset.
  mem_t mem = init_mem();

  always_ff @(posedge clock) begin
    if (we && !reset) begin
      mem[addr] <= wdata;
    end
  end

  // Separate process samples the pre-write value, giving read-before-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/jogo_memoria_fluxo_dados_param.sv
// Purpose : parametrised memory-game datapath (address/sequence counters, move register,
//           sequence RAM, move edge detect, per-move timeout) driven by the control unit.
// Latency : comparators combinational; RAM read, jogada_feita and counters 1 cycle.
// Backpressure: none; strobes act every cycle they are high (reset > zera_* > conta_*/registra_r).
// Ports   : clock/reset, botoes, limite, zera_*/conta_*/registra_r/escreve_m strobes in;
//           status flags, timeout flags and db_* debug buses out.
// Config  : define JOGO_TIMEOUT_EN to build the timeout counter; otherwise timeout outputs are 0.
module jogo_memoria_fluxo_dados_param
  import jogo_memoria_pkg::*;
#(
  parameter int N_BOTOES = N_BOTOES_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int T_W      = $clog2(TIMEOUT)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [ADDR_W-1:0]   limite,
  input  logic                zera_e,
  input  logic                conta_e,
  input  logic                zera_s,
  input  logic                conta_s,
  input  logic                zera_r,
  input  logic                registra_r,
  input  logic                escreve_m,
  input  logic                zera_t,
  input  logic                conta_t,
  output logic                igual,
  output logic                jogada_valida,
  output logic                endereco_igual_sequencia,
  output logic                endereco_maior_sequencia,
  output logic                fim_e,
  output logic                fim_s,
  output logic                tem_jogada,
  output logic                jogada_feita,
  output logic                timeout,
  output logic                timeout_led,
  output logic [ADDR_W-1:0]   db_endereco,
  output logic [ADDR_W-1:0]   db_sequencia,
  output logic [N_BOTOES-1:0] db_jogada,
  output logic [N_BOTOES-1:0] db_memoria
);

  logic [ADDR_W-1:0]   endereco;
  logic [ADDR_W-1:0]   sequencia;
  logic [N_BOTOES-1:0] jogada;
  logic [N_BOTOES-1:0] mem_dado;
  logic                tem_jogada_prev;

  // Address counter: wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || zera_e) begin
      endereco <= '0;
    end else if (conta_e) begin
      endereco <= endereco + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || zera_s) begin
      sequencia <= '0;
    end else if (conta_s) begin
      sequencia <= sequencia + 1'b1;
    end
  end

  // Move register; clear beats load.
  always_ff @(posedge clock) begin
    if (reset || zera_r) begin
      jogada <= '0;
    end else if (registra_r) begin
      jogada <= botoes;
    end
  end

  ram_sync_param #(
    .W      (N_BOTOES),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (escreve_m),
    .addr  (endereco),
    .wdata (jogada),
    .rdata (mem_dado)
  );

  assign tem_jogada = |botoes;

  // Rising-edge detector; pulse is registered so it lands one cycle after the press.
  // zera_s clears the history so a button still held at the start of a round re-arms.
  always_ff @(posedge clock) begin
    if (reset) begin
      tem_jogada_prev <= 1'b0;
      jogada_feita    <= 1'b0;
    end else begin
      tem_jogada_prev <= zera_s ? 1'b0 : tem_jogada;
      jogada_feita    <= tem_jogada & ~tem_jogada_prev;
    end
  end

`ifdef JOGO_TIMEOUT_EN
  logic [T_W-1:0] tcount;

  // Saturates at the last count so timeout holds until explicitly cleared.
  always_ff @(posedge clock) begin
    if (reset || zera_t || zera_r) begin
      tcount <= '0;
    end else if (conta_t && (tcount != T_W'(TIMEOUT - 1))) begin
      tcount <= tcount + 1'b1;
    end
  end

  assign timeout     = (tcount == T_W'(TIMEOUT - 1));
  assign timeout_led = (tcount >= T_W'(TIMEOUT - TIMEOUT / 10));
`else
  logic unused_timeout_ctrl;
  assign unused_timeout_ctrl = zera_t ^ conta_t;
  assign timeout     = 1'b0;
  assign timeout_led = 1'b0;
`endif

  assign igual                    = (mem_dado == jogada);
  assign jogada_valida            = one_hot(32'(jogada));
  assign endereco_igual_sequencia = (endereco == sequencia);
  assign endereco_maior_sequencia = (endereco > sequencia);
  assign fim_e                    = (endereco == limite);
  assign fim_s                    = (sequencia == limite);

  assign db_endereco  = endereco;
  assign db_sequencia = sequencia;
  assign db_jogada    = jogada;
  assign db_memoria   = mem_dado;

endmodule

// File: tb/tb_jogo_memoria_fluxo_dados_param.sv
module tb_jogo_memoria_fluxo_dados_param;

  localparam int NB    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TO    = 20;
`ifdef JOGO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] botoes;
  logic [AW-1:0] limite;
  logic zera_e, conta_e, zera_s, conta_s, zera_r, registra_r, escreve_m, zera_t, conta_t;
  logic igual, jogada_valida, endereco_igual_sequencia, endereco_maior_sequencia;
  logic fim_e, fim_s, tem_jogada, jogada_feita, timeout, timeout_led;
  logic [AW-1:0] db_endereco, db_sequencia;
  logic [NB-1:0] db_jogada, db_memoria;

  jogo_memoria_fluxo_dados_param #(
    .N_BOTOES (NB),
    .DEPTH    (DEPTH),
    .TIMEOUT  (TO)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .botoes                   (botoes),
    .limite                   (limite),
    .zera_e                   (zera_e),
    .conta_e                  (conta_e),
    .zera_s                   (zera_s),
    .conta_s                  (conta_s),
    .zera_r                   (zera_r),
    .registra_r               (registra_r),
    .escreve_m                (escreve_m),
    .zera_t                   (zera_t),
    .conta_t                  (conta_t),
    .igual                    (igual),
    .jogada_valida            (jogada_valida),
    .endereco_igual_sequencia (endereco_igual_sequencia),
    .endereco_maior_sequencia (endereco_maior_sequencia),
    .fim_e                    (fim_e),
    .fim_s                    (fim_s),
    .tem_jogada               (tem_jogada),
    .jogada_feita             (jogada_feita),
    .timeout                  (timeout),
    .timeout_led              (timeout_led),
    .db_endereco              (db_endereco),
    .db_sequencia             (db_sequencia),
    .db_jogada                (db_jogada),
    .db_memoria               (db_memoria)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: abstract game state, RAM image only where the bench knows it.
  int         m_e, m_s, m_tc;
  logic [3:0] m_j, m_rd;
  bit         m_rd_known, m_prev, m_feita;
  logic [3:0] m_mem [DEPTH];
  bit         m_known [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; zera_e = 0; conta_e = 0; zera_s = 0; conta_s = 0;
    zera_r = 0; registra_r = 0; escreve_m = 0; zera_t = 0; conta_t = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      m_e = 0; m_s = 0; m_j = 0; m_rd = 0; m_rd_known = 1;
      m_prev = 0; m_feita = 0; m_tc = 0;
    end else begin
      m_rd       = m_mem[m_e];
      m_rd_known = m_known[m_e];
      if (escreve_m) begin
        m_mem[m_e]   = m_j;
        m_known[m_e] = 1;
      end
      m_feita = (botoes != 0) && !m_prev;
      m_prev  = zera_s ? 1'b0 : (botoes != 0);
      if (zera_e) m_e = 0; else if (conta_e) m_e = (m_e + 1) % DEPTH;
      if (zera_s) m_s = 0; else if (conta_s) m_s = (m_s + 1) % DEPTH;
      if (zera_r) m_j = 0; else if (registra_r) m_j = botoes;
      if (zera_t || zera_r) m_tc = 0;
      else if (conta_t && m_tc < TO - 1) m_tc = m_tc + 1;
    end
  endtask

  task automatic check_all();
    int ones;
    ones = 0;
    for (int b = 0; b < NB; b++) ones += int'(m_j[b]);
    chk("db_endereco", 32'(db_endereco), m_e);
    chk("db_sequencia", 32'(db_sequencia), m_s);
    chk("db_jogada", 32'(db_jogada), 32'(m_j));
    chk("jogada_valida", 32'(jogada_valida), 32'(ones == 1));
    chk("end_igual_seq", 32'(endereco_igual_sequencia), 32'(m_e == m_s));
    chk("end_maior_seq", 32'(endereco_maior_sequencia), 32'(m_e > m_s));
    chk("fim_e", 32'(fim_e), 32'(m_e == int'(limite)));
    chk("fim_s", 32'(fim_s), 32'(m_s == int'(limite)));
    chk("tem_jogada", 32'(tem_jogada), 32'(botoes != 0));
    chk("jogada_feita", 32'(jogada_feita), 32'(m_feita));
    chk("timeout", 32'(timeout), 32'(TO_EN && m_tc == TO - 1));
    chk("timeout_led", 32'(timeout_led), 32'(TO_EN && m_tc >= TO - TO / 10));
    if (m_rd_known) begin
      chk("db_memoria", 32'(db_memoria), 32'(m_rd));
      chk("igual", 32'(igual), 32'(m_rd == m_j));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int pulses;
    int first_pulse;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 4'b0000;
      m_known[i] = 0;
    end
    m_mem[0] = 4'b0100;   // first entry of the boot sequence
    m_known[0] = 1;
    m_e = 0; m_s = 0; m_j = 0; m_rd = 0; m_rd_known = 0;
    m_prev = 0; m_feita = 0; m_tc = 0;

    // Reset state
    idle(); botoes = 0; limite = 4'd5; reset = 1;
    tick(); tick();
    chk("rst_endereco", 32'(db_endereco), 0);
    chk("rst_jogada_feita", 32'(jogada_feita), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_igual", 32'(igual), 1);
    chk("rst_jogada_valida", 32'(jogada_valida), 0);
    reset = 0;

    // Address counter walk with wrap; fim_e only at limite=5
    conta_e = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("walk_endereco", 32'(db_endereco), k % 16);
      chk("walk_fim_e", 32'(fim_e), 32'((k % 16) == 5));
    end
    idle();

    // Move register vs RAM[0]
    botoes = 4'b0100; registra_r = 1; tick();
    registra_r = 0; botoes = 0; tick();
    chk("mv_igual_0100", 32'(igual), 1);
    chk("mv_valida_0100", 32'(jogada_valida), 1);
    botoes = 4'b0110; registra_r = 1; tick();
    registra_r = 0; botoes = 0; tick();
    chk("mv_igual_0110", 32'(igual), 0);
    chk("mv_valida_0110", 32'(jogada_valida), 0);

    // Read-before-write at address 3
    zera_e = 1; tick(); zera_e = 0;
    conta_e = 1; tick(); tick(); tick(); conta_e = 0;
    botoes = 4'b0001; registra_r = 1; tick(); registra_r = 0; botoes = 0;
    escreve_m = 1; tick(); escreve_m = 0;
    botoes = 4'b1000; registra_r = 1; tick(); registra_r = 0; botoes = 0;
    escreve_m = 1; tick(); escreve_m = 0;
    chk("rbw_old", 32'(db_memoria), 32'(4'b0001));
    tick();
    chk("rbw_new", 32'(db_memoria), 32'(4'b1000));

    // Single pulse on a held press
    botoes = 0; tick(); tick();
    botoes = 4'b0001;
    pulses = 0; first_pulse = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (jogada_feita) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
    chk("edge_pulses", pulses, 1);
    chk("edge_first", first_pulse, 1);
    botoes = 0; tick();

    // Timeout window
    zera_t = 1; tick(); zera_t = 0;
    conta_t = 1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk("to_timeout", 32'(timeout), 32'(TO_EN && ((k < TO - 1) ? k : TO - 1) == TO - 1));
      chk("to_led", 32'(timeout_led), 32'(TO_EN && ((k < TO - 1) ? k : TO - 1) >= TO - 2));
    end
    conta_t = 0; zera_r = 1; tick(); zera_r = 0;
    chk("to_clr_timeout", 32'(timeout), 0);
    chk("to_clr_led", 32'(timeout_led), 0);

    // Mid-count reset keeps RAM, ignores write during reset
    zera_e = 1; zera_s = 1; tick(); idle();
    conta_e = 1; repeat (7) tick(); conta_e = 0;
    conta_s = 1; repeat (2) tick(); conta_s = 0;
    botoes = 4'b0001; registra_r = 1; tick(); registra_r = 0;
    escreve_m = 1; tick(); escreve_m = 0;
    botoes = 4'b0010; registra_r = 1; tick(); registra_r = 0; botoes = 0;
    chk("pre_rst_jogada", 32'(db_jogada), 32'(4'b0010));
    reset = 1; escreve_m = 1; tick(); idle();
    chk("mid_rst_end", 32'(db_endereco), 0);
    chk("mid_rst_seq", 32'(db_sequencia), 0);
    chk("mid_rst_jog", 32'(db_jogada), 0);
    conta_e = 1; repeat (3) tick(); conta_e = 0; tick();
    chk("ram_kept_3", 32'(db_memoria), 32'(4'b1000));
    conta_e = 1; repeat (4) tick(); conta_e = 0; tick();
    chk("ram_kept_7", 32'(db_memoria), 32'(4'b0001));

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      reset      = ($urandom_range(0, 59) == 0);
      zera_e     = ($urandom_range(0, 11) == 0);
      conta_e    = ($urandom_range(0, 1) == 0);
      zera_s     = ($urandom_range(0, 11) == 0);
      conta_s    = ($urandom_range(0, 2) == 0);
      zera_r     = ($urandom_range(0, 11) == 0);
      registra_r = ($urandom_range(0, 2) == 0);
      escreve_m  = ($urandom_range(0, 4) == 0);
      zera_t     = ($urandom_range(0, 29) == 0);
      conta_t    = ($urandom_range(0, 3) != 0);
      botoes     = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) limite = 4'($urandom_range(0, 15));
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
